vend_actuator: RTL and testbench

Physical-output side of the vending machine. It consumes the `dispense` and `give_change` levels decoded from the controller state and drives the product motor and the coin-ejector solenoids with timed pulses. It returns one-cycle completion strobes to the controller. Change is paid greedily in quarters, dimes and nickels from a latched cent amount.

---
 rtl/vend_pkg.sv | 37 +++
 rtl/vend_actuator_coin_select.sv | 28 ++
 rtl/vend_actuator.sv | 182 ++++++++++++++++++
 tb/tb_vend_actuator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: controller state codes, actuator FSM states,
// coin values and coin one-hot bit positions.
package vend_pkg;

    typedef enum logic [2:0] {
        WAITSELECTION = 3'd0,
        WAITCOINS     = 3'd1,
        CHECKCOINS    = 3'd2,
        DISPENSING    = 3'd3,
        CANCEL        = 3'd4,
        CHANGERETURN  = 3'd5
    } ctrl_state_e;

    typedef enum logic [1:0] {
        ACT_IDLE  = 2'd0,
        ACT_MOTOR = 2'd1,
        ACT_PULSE = 2'd2,
        ACT_GAP   = 2'd3
    } act_state_e;

    localparam int unsigned QUARTER = 25;
    localparam int unsigned DIME    = 10;
    localparam int unsigned NICKEL  = 5;

    // One-hot coin select layout: {quarter, dime, nickel}
    localparam int COIN_Q_BIT = 2;
    localparam int COIN_D_BIT = 1;
    localparam int COIN_N_BIT = 0;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vend_actuator_coin_select.sv
// Greedy coin choice for the amount still owed; purely combinational.
// Amounts below a nickel still report a nickel; the caller never pays those.
module coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 7
) (
    input  logic [AMT_W-1:0] remaining,
    output logic [2:0]       coin_oh,
    output logic [AMT_W-1:0] coin_val
);

    always_comb begin
        coin_oh  = '0;
        coin_val = AMT_W'(NICKEL);
        coin_oh[COIN_N_BIT] = 1'b1;
        if (remaining >= AMT_W'(QUARTER)) begin
            coin_oh             = '0;
            coin_oh[COIN_Q_BIT] = 1'b1;
            coin_val            = AMT_W'(QUARTER);
        end else if (remaining >= AMT_W'(DIME)) begin
            coin_oh             = '0;
            coin_oh[COIN_D_BIT] = 1'b1;
            coin_val            = AMT_W'(DIME);
        end
    end

endmodule

// File: rtl/vend_actuator.sv
// Drives the product motor and coin solenoids from dispense/give_change level rises.
// Every output is a flop; requests arriving while busy are held as pending flags.
module vend_actuator
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int AMT_W        = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dispense,
    input  logic             give_change,
    input  logic [AMT_W-1:0] change_cents,
    output logic             motor_on,
    output logic             quarter_out,
    output logic             dime_out,
    output logic             nickel_out,
    output logic             dispense_done,
    output logic             change_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(max3(MOTOR_CYCLES, PULSE_CYCLES, GAP_CYCLES)) + 1;

    act_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [AMT_W-1:0] chg_amt_q, chg_amt_d;
    logic [2:0]       coin_q, coin_d;
    logic             dispense_q, give_change_q;
    logic             disp_pend_q, disp_pend_d;
    logic             chg_pend_q, chg_pend_d;
    logic             motor_on_q, motor_on_d;
    logic             quarter_q, quarter_d;
    logic             dime_q, dime_d;
    logic             nickel_q, nickel_d;
    logic             disp_done_q, disp_done_d;
    logic             chg_done_q, chg_done_d;
    logic             busy_q, busy_d;

    logic             dispense_rise, chg_rise;
    logic             start_vend, start_chg;
    logic [AMT_W-1:0] sel_src;
    logic [2:0]       sel_oh;
    logic [AMT_W-1:0] sel_val;

    // From IDLE the next coin comes from the freshly latched amount, otherwise from the balance
    assign sel_src = (state_q == ACT_IDLE) ? chg_amt_q : remaining_q;

    coin_select #(.AMT_W(AMT_W)) u_coin_select (
        .remaining (sel_src),
        .coin_oh   (sel_oh),
        .coin_val  (sel_val)
    );

    always_comb begin
        dispense_rise = dispense & ~dispense_q;
        chg_rise      = give_change & ~give_change_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        remaining_d   = remaining_q;
        coin_d        = coin_q;
        chg_amt_d     = chg_rise ? change_cents : chg_amt_q;
        start_vend    = 1'b0;
        start_chg     = 1'b0;
        disp_done_d   = 1'b0;
        chg_done_d    = 1'b0;

        case (state_q)
            ACT_IDLE: begin
                if (disp_pend_q) begin
                    start_vend = 1'b1;
                    state_d    = ACT_MOTOR;
                    cnt_d      = CNT_W'(MOTOR_CYCLES - 1);
                end else if (chg_pend_q && !dispense_rise) begin
                    // A vend rising this cycle keeps priority; change waits one more cycle
                    start_chg = 1'b1;
                    if (chg_amt_q < AMT_W'(NICKEL)) begin
                        chg_done_d  = 1'b1;
                        remaining_d = '0;
                    end else begin
                        state_d     = ACT_PULSE;
                        cnt_d       = CNT_W'(PULSE_CYCLES - 1);
                        remaining_d = chg_amt_q;
                        coin_d      = sel_oh;
                    end
                end
            end
            ACT_MOTOR: begin
                if (cnt_q == '0) begin
                    state_d     = ACT_IDLE;
                    disp_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACT_PULSE: begin
                if (cnt_q == '0) begin
                    remaining_d = (remaining_q >= sel_val) ? remaining_q - sel_val : '0;
                    state_d     = ACT_GAP;
                    cnt_d       = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACT_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (remaining_q >= AMT_W'(NICKEL)) begin
                    state_d = ACT_PULSE;
                    cnt_d   = CNT_W'(PULSE_CYCLES - 1);
                    coin_d  = sel_oh;
                end else begin
                    state_d     = ACT_IDLE;
                    chg_done_d  = 1'b1;
                    remaining_d = '0;
                end
            end
            default: begin
                state_d = ACT_IDLE;
            end
        endcase

        disp_pend_d = dispense_rise | (disp_pend_q & ~start_vend);
        chg_pend_d  = chg_rise | (chg_pend_q & ~start_chg);

        motor_on_d = (state_d == ACT_MOTOR);
        quarter_d  = (state_d == ACT_PULSE) & coin_d[COIN_Q_BIT];
        dime_d     = (state_d == ACT_PULSE) & coin_d[COIN_D_BIT];
        nickel_d   = (state_d == ACT_PULSE) & coin_d[COIN_N_BIT];
        busy_d     = (state_d != ACT_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACT_IDLE;
            cnt_q         <= '0;
            remaining_q   <= '0;
            chg_amt_q     <= '0;
            coin_q        <= '0;
            dispense_q    <= 1'b0;
            give_change_q <= 1'b0;
            disp_pend_q   <= 1'b0;
            chg_pend_q    <= 1'b0;
            motor_on_q    <= 1'b0;
            quarter_q     <= 1'b0;
            dime_q        <= 1'b0;
            nickel_q      <= 1'b0;
            disp_done_q   <= 1'b0;
            chg_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            remaining_q   <= remaining_d;
            chg_amt_q     <= chg_amt_d;
            coin_q        <= coin_d;
            dispense_q    <= dispense;
            give_change_q <= give_change;
            disp_pend_q   <= disp_pend_d;
            chg_pend_q    <= chg_pend_d;
            motor_on_q    <= motor_on_d;
            quarter_q     <= quarter_d;
            dime_q        <= dime_d;
            nickel_q      <= nickel_d;
            disp_done_q   <= disp_done_d;
            chg_done_q    <= chg_done_d;
            busy_q        <= busy_d;
        end
    end

    assign motor_on      = motor_on_q;
    assign quarter_out   = quarter_q;
    assign dime_out      = dime_q;
    assign nickel_out    = nickel_q;
    assign dispense_done = disp_done_q;
    assign change_done   = chg_done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_vend_actuator.sv
// Directed per-cycle vectors for vend_actuator plus a hand-written async-reset sequence.
module tb_vend_actuator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dispense;
    logic       give_change;
    logic [6:0] change_cents;
    logic       motor_on, quarter_out, dime_out, nickel_out;
    logic       dispense_done, change_done, busy;
    logic [6:0] outs;

    vend_actuator #(
        .MOTOR_CYCLES (8),
        .PULSE_CYCLES (2),
        .GAP_CYCLES   (2),
        .AMT_W        (7)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dispense      (dispense),
        .give_change   (give_change),
        .change_cents  (change_cents),
        .motor_on      (motor_on),
        .quarter_out   (quarter_out),
        .dime_out      (dime_out),
        .nickel_out    (nickel_out),
        .dispense_done (dispense_done),
        .change_done   (change_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // {motor, quarter, dime, nickel, dispense_done, change_done, busy}
    assign outs = {motor_on, quarter_out, dime_out, nickel_out, dispense_done, change_done, busy};

    localparam logic [6:0] O_IDLE = 7'b000_0000;
    localparam logic [6:0] O_MOT  = 7'b100_0001;
    localparam logic [6:0] O_DD   = 7'b000_0100;
    localparam logic [6:0] O_Q    = 7'b010_0001;
    localparam logic [6:0] O_D    = 7'b001_0001;
    localparam logic [6:0] O_N    = 7'b000_1001;
    localparam logic [6:0] O_GAP  = 7'b000_0001;
    localparam logic [6:0] O_CD   = 7'b000_0010;

    typedef struct {
        int         grp;
        logic       rst_n;
        logic       dsp;
        logic       chg;
        logic [6:0] cents;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic string gname(input int g);
        case (g)
            0:       return "reset";
            1:       return "vend";
            2:       return "change40";
            3:       return "change3";
            4:       return "both_rise";
            5:       return "redispense";
            default: return "other";
        endcase
    endfunction

    task automatic add(input int grp, input logic r, input logic d, input logic g,
                       input logic [6:0] c, input logic [6:0] e, input int n);
        vec_t v;
        v.grp = grp; v.rst_n = r; v.dsp = d; v.chg = g; v.cents = c; v.exp = e;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input logic [6:0] exp);
        n_vec++;
        if (outs !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: outputs %b, required %b", nm, idx, outs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; dispense = 1'b0; give_change = 1'b0; change_cents = '0;

        add(0, 0, 0, 0, 0,  O_IDLE, 2);
        add(0, 1, 0, 0, 0,  O_IDLE, 1);
        // dispense held 3 cycles: 8 motor cycles, then done with busy low
        add(1, 1, 1, 0, 0,  O_IDLE, 1);
        add(1, 1, 1, 0, 0,  O_MOT,  2);
        add(1, 1, 0, 0, 0,  O_MOT,  6);
        add(1, 1, 0, 0, 0,  O_DD,   1);
        add(1, 1, 0, 0, 0,  O_IDLE, 1);
        // 40 cents: quarter, dime, nickel; change_cents changed after the rise must not matter
        add(2, 1, 0, 1, 40, O_IDLE, 1);
        add(2, 1, 0, 1, 0,  O_Q,    2);
        add(2, 1, 0, 1, 0,  O_GAP,  2);
        add(2, 1, 0, 1, 0,  O_D,    2);
        add(2, 1, 0, 1, 0,  O_GAP,  2);
        add(2, 1, 0, 1, 0,  O_N,    2);
        add(2, 1, 0, 1, 0,  O_GAP,  2);
        add(2, 1, 0, 1, 0,  O_CD,   1);
        add(2, 1, 0, 0, 0,  O_IDLE, 1);
        // 3 cents: nothing paid, immediate done
        add(3, 1, 0, 1, 3,  O_IDLE, 1);
        add(3, 1, 0, 1, 3,  O_CD,   1);
        add(3, 1, 0, 0, 0,  O_IDLE, 1);
        // simultaneous rises: vend, one idle-state cycle, then one quarter
        add(4, 1, 1, 1, 25, O_IDLE, 1);
        add(4, 1, 1, 1, 25, O_MOT,  8);
        add(4, 1, 0, 1, 0,  O_DD,   1);
        add(4, 1, 0, 1, 0,  O_Q,    2);
        add(4, 1, 0, 1, 0,  O_GAP,  2);
        add(4, 1, 0, 1, 0,  O_CD,   1);
        add(4, 1, 0, 0, 0,  O_IDLE, 1);
        // second rise during the motor run queues exactly one more vend
        add(5, 1, 1, 0, 0,  O_IDLE, 1);
        add(5, 1, 0, 0, 0,  O_MOT,  1);
        add(5, 1, 1, 0, 0,  O_MOT,  1);
        add(5, 1, 0, 0, 0,  O_MOT,  6);
        add(5, 1, 0, 0, 0,  O_DD,   1);
        add(5, 1, 0, 0, 0,  O_MOT,  8);
        add(5, 1, 0, 0, 0,  O_DD,   1);
        add(5, 1, 0, 0, 0,  O_IDLE, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n        = vecs[i].rst_n;
            dispense     = vecs[i].dsp;
            give_change  = vecs[i].chg;
            change_cents = vecs[i].cents;
            step();
            check(gname(vecs[i].grp), i, vecs[i].exp);
        end

        // 50 cents, reset lands mid second quarter
        give_change = 1'b1; change_cents = 7'd50;
        step();
        check("pay50_rise", 0, O_IDLE);
        step(); check("pay50_q1", 1, O_Q);
        step(); step(); step();
        step(); check("pay50_q2", 5, O_Q);
        #3 rst_n = 1'b0;
        #1 check("async_reset", 0, O_IDLE);
        give_change = 1'b0; change_cents = '0;
        step(); check("in_reset", 0, O_IDLE);
        step(); check("in_reset", 1, O_IDLE);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); check("no_done_after_reset", i, O_IDLE);
        end
        give_change = 1'b1; change_cents = 7'd10;
        step(); check("pay10_rise", 0, O_IDLE);
        step(); check("pay10_dime", 1, O_D);
        step(); check("pay10_dime", 2, O_D);
        step(); check("pay10_gap", 3, O_GAP);
        step(); check("pay10_gap", 4, O_GAP);
        step(); check("pay10_done", 5, O_CD);
        give_change = 1'b0;
        step(); check("pay10_idle", 6, O_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
